// File: rtl/pc_sequencer.sv
// Instruction sequencer for an 8-bit program counter: fetches one opcode per
// instruction and drives the counter's Load/CountEn/A, with a small return stack.
module pc_sequencer #(
    parameter int                WIDTH       = 8,
    parameter int                STACK_DEPTH = 4,
    parameter logic [WIDTH-1:0]  RESET_VEC   = '0
) (
    input  logic                               Clk,
    input  logic                               nReset,
    input  logic                               Start,
    input  logic                               InstrValid,
    input  logic [2:0]                         Opcode,
    input  logic [WIDTH-1:0]                   Target,
    input  logic                               CondZ,
    input  logic [WIDTH-1:0]                   PcIn,
    output logic                               PcLoad,
    output logic                               PcCountEn,
    output logic [WIDTH-1:0]                   PcA,
    output logic                               InstrReq,
    output logic                               Busy,
    output logic                               Halted,
    output logic                               Error,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   StackLevel,
    output logic [2:0]                         dbg_state
);

    localparam int LW = $clog2(STACK_DEPTH + 1);
    localparam int PW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_JMP  = 3'd1;
    localparam logic [2:0] OP_BRZ  = 3'd2;
    localparam logic [2:0] OP_CALL = 3'd3;
    localparam logic [2:0] OP_RET  = 3'd4;
    localparam logic [2:0] OP_HALT = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOADVEC = 3'd1,
        S_FETCH   = 3'd2,
        S_EXEC    = 3'd3,
        S_HALTED  = 3'd4,
        S_ERROR   = 3'd5
    } state_t;

    state_t             state;
    logic [2:0]         instr_op;
    logic [WIDTH-1:0]   stack_mem [STACK_DEPTH];
    logic [PW-1:0]      push_idx;
    logic [PW-1:0]      top_idx;
    logic               stack_full;
    logic               stack_empty;

    assign push_idx    = StackLevel[PW-1:0];
    assign top_idx     = push_idx - PW'(1);
    assign stack_full  = (StackLevel == LW'(STACK_DEPTH));
    assign stack_empty = (StackLevel == '0);
    assign dbg_state   = state;

    // PC controls for EXEC are decoded while accepting the instruction in FETCH,
    // so during EXEC they come straight from flops.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state      <= S_IDLE;
            instr_op   <= '0;
            StackLevel <= '0;
            PcLoad     <= 1'b0;
            PcCountEn  <= 1'b0;
            PcA        <= '0;
            InstrReq   <= 1'b0;
            Busy       <= 1'b0;
            Halted     <= 1'b0;
            Error      <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) stack_mem[i] <= '0;
        end else begin
            case (state)
                S_IDLE, S_HALTED, S_ERROR: begin
                    if (Start) begin
                        state      <= S_LOADVEC;
                        StackLevel <= '0;
                        PcLoad     <= 1'b1;
                        PcA        <= RESET_VEC;
                        Busy       <= 1'b1;
                        Halted     <= 1'b0;
                        Error      <= 1'b0;
                    end
                end
                S_LOADVEC: begin
                    state    <= S_FETCH;
                    PcLoad   <= 1'b0;
                    PcA      <= '0;
                    InstrReq <= 1'b1;
                end
                S_FETCH: begin
                    if (InstrValid) begin
                        state    <= S_EXEC;
                        InstrReq <= 1'b0;
                        instr_op <= Opcode;
                        case (Opcode)
                            OP_NOP: PcCountEn <= 1'b1;
                            OP_JMP: begin
                                PcLoad <= 1'b1;
                                PcA    <= Target;
                            end
                            OP_BRZ: begin
                                if (CondZ) begin
                                    PcLoad <= 1'b1;
                                    PcA    <= Target;
                                end else begin
                                    PcCountEn <= 1'b1;
                                end
                            end
                            OP_CALL: begin
                                if (!stack_full) begin
                                    PcLoad <= 1'b1;
                                    PcA    <= Target;
                                end
                            end
                            OP_RET: begin
                                if (!stack_empty) begin
                                    PcLoad <= 1'b1;
                                    PcA    <= stack_mem[top_idx];
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                S_EXEC: begin
                    PcLoad    <= 1'b0;
                    PcCountEn <= 1'b0;
                    PcA       <= '0;
                    case (instr_op)
                        OP_NOP, OP_JMP, OP_BRZ: begin
                            state    <= S_FETCH;
                            InstrReq <= 1'b1;
                        end
                        OP_CALL: begin
                            if (stack_full) begin
                                state <= S_ERROR;
                                Busy  <= 1'b0;
                                Error <= 1'b1;
                            end else begin
                                stack_mem[push_idx] <= PcIn + WIDTH'(1);
                                StackLevel          <= StackLevel + LW'(1);
                                state               <= S_FETCH;
                                InstrReq            <= 1'b1;
                            end
                        end
                        OP_RET: begin
                            if (stack_empty) begin
                                state <= S_ERROR;
                                Busy  <= 1'b0;
                                Error <= 1'b1;
                            end else begin
                                StackLevel <= StackLevel - LW'(1);
                                state      <= S_FETCH;
                                InstrReq   <= 1'b1;
                            end
                        end
                        OP_HALT: begin
                            state  <= S_HALTED;
                            Busy   <= 1'b0;
                            Halted <= 1'b1;
                        end
                        default: begin
                            state <= S_ERROR;
                            Busy  <= 1'b0;
                            Error <= 1'b1;
                        end
                    endcase
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: a behavioural program counter plus an instruction-level
// reference model (return stack as a queue) checked after every instruction.
module tb_pc_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       instr_valid = 1'b0;
    logic [2:0] opcode = '0;
    logic [7:0] target = '0;
    logic       cond_z = 1'b0;
    logic [7:0] pc;
    logic       pc_load, pc_count_en, instr_req, busy, halted, error;
    logic [7:0] pc_a;
    logic [2:0] stack_level;
    logic [2:0] dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] exp_q[$];
    logic [7:0] exp_pc   = '0;
    logic       exp_halt = 1'b0;
    logic       exp_err  = 1'b0;

    pc_sequencer #(.WIDTH(8), .STACK_DEPTH(4), .RESET_VEC(8'd0)) dut (
        .Clk(clk), .nReset(rst_n), .Start(start), .InstrValid(instr_valid),
        .Opcode(opcode), .Target(target), .CondZ(cond_z), .PcIn(pc),
        .PcLoad(pc_load), .PcCountEn(pc_count_en), .PcA(pc_a),
        .InstrReq(instr_req), .Busy(busy), .Halted(halted), .Error(error),
        .StackLevel(stack_level), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // Stand-in for progcount: load has priority, otherwise count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           pc <= '0;
        else if (pc_load)     pc <= pc_a;
        else if (pc_count_en) pc <= pc + 8'd1;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_load"}, pc_load, 0);
        check({tag, "_cnt"}, pc_count_en, 0);
        check({tag, "_a"}, pc_a, 0);
        check({tag, "_req"}, instr_req, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_halted"}, halted, 0);
        check({tag, "_error"}, error, 0);
        check({tag, "_lvl"}, stack_level, 0);
    endtask

    // Instruction-level model: what the PC must do and where the machine ends up.
    task automatic model_step(input logic [2:0] op, input logic [7:0] tgt, input logic cz,
                              output logic e_load, output logic e_cnt, output logic [7:0] e_a);
        e_load = 1'b0; e_cnt = 1'b0; e_a = '0;
        case (op)
            3'd0: begin e_cnt = 1'b1; exp_pc = exp_pc + 8'd1; end
            3'd1: begin e_load = 1'b1; e_a = tgt; exp_pc = tgt; end
            3'd2: begin
                if (cz) begin e_load = 1'b1; e_a = tgt; exp_pc = tgt; end
                else begin e_cnt = 1'b1; exp_pc = exp_pc + 8'd1; end
            end
            3'd3: begin
                if (exp_q.size() == 4) exp_err = 1'b1;
                else begin
                    exp_q.push_back(exp_pc + 8'd1);
                    e_load = 1'b1; e_a = tgt; exp_pc = tgt;
                end
            end
            3'd4: begin
                if (exp_q.size() == 0) exp_err = 1'b1;
                else begin
                    exp_pc = exp_q.pop_back();
                    e_load = 1'b1; e_a = exp_pc;
                end
            end
            3'd5: exp_halt = 1'b1;
            default: exp_err = 1'b1;
        endcase
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        exp_q.delete();
        exp_pc = 8'd0; exp_halt = 1'b0; exp_err = 1'b0;
        check("lv_load", pc_load, 1);
        check("lv_a", pc_a, 0);
        check("lv_cnt", pc_count_en, 0);
        check("lv_busy", busy, 1);
        check("lv_lvl", stack_level, 0);
        check("lv_error", error, 0);
        check("lv_halted", halted, 0);
        @(negedge clk);
        check("f_req", instr_req, 1);
        check("f_load", pc_load, 0);
        check("f_pc", pc, exp_pc);
    endtask

    // Entered at a falling edge while the DUT sits in FETCH.
    task automatic exec_instr(input logic [2:0] op, input logic [7:0] tgt, input logic cz,
                              input int gap);
        logic e_load, e_cnt;
        logic [7:0] e_a;
        for (int i = 0; i < gap; i++) begin
            instr_valid = 1'b0;
            opcode = 3'($urandom);
            start = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("wait_req", instr_req, 1);
            check("wait_pc", pc, exp_pc);
            check("wait_ctl", {pc_load, pc_count_en}, 0);
        end
        instr_valid = 1'b1; opcode = op; target = tgt; cond_z = cz;
        start = 1'($urandom_range(0, 1));
        model_step(op, tgt, cz, e_load, e_cnt, e_a);
        @(negedge clk);
        instr_valid = 1'($urandom_range(0, 1));
        opcode = 3'($urandom); target = 8'($urandom); cond_z = 1'($urandom);
        check("ex_load", pc_load, e_load);
        check("ex_cnt", pc_count_en, e_cnt);
        check("ex_a", pc_a, e_a);
        check("ex_excl", pc_load & pc_count_en, 0);
        check("ex_req", instr_req, 0);
        @(negedge clk);
        start = 1'b0; instr_valid = 1'b0;
        check("pc", pc, exp_pc);
        check("lvl", stack_level, exp_q.size());
        check("halted", halted, exp_halt);
        check("error", error, exp_err);
        check("busy", busy, !(exp_halt || exp_err));
        check("req", instr_req, !(exp_halt || exp_err));
        check("ctl_idle", {pc_load, pc_count_en, pc_a}, 0);
    endtask

    initial begin
        int r;
        logic [2:0] op;
        repeat (2) @(negedge clk);
        check_all_zero("rst");
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("idle");

        // Linear run with a jump and an address wrap, no fetch stalls.
        do_start();
        exec_instr(3'd0, 8'd0, 1'b0, 0);
        exec_instr(3'd0, 8'd0, 1'b0, 0);
        exec_instr(3'd1, 8'd254, 1'b0, 0);
        exec_instr(3'd0, 8'd0, 1'b0, 0);
        check("pc_255", pc, 8'd255);
        exec_instr(3'd0, 8'd0, 1'b0, 0);
        check("pc_wrap", pc, 8'd0);

        // Branch not taken, then taken.
        exec_instr(3'd1, 8'd5, 1'b0, 0);
        exec_instr(3'd2, 8'h40, 1'b0, 0);
        check("brz_nt", pc, 8'd6);
        exec_instr(3'd2, 8'h40, 1'b1, 1);
        check("brz_t", pc, 8'h40);

        // Nested call/return.
        exec_instr(3'd1, 8'h10, 1'b0, 0);
        exec_instr(3'd3, 8'h80, 1'b0, 0);
        exec_instr(3'd3, 8'hA0, 1'b0, 0);
        exec_instr(3'd4, 8'h00, 1'b0, 0);
        check("ret1", pc, 8'h81);
        exec_instr(3'd4, 8'h00, 1'b0, 0);
        check("ret2", pc, 8'h11);

        // Stack overflow, then underflow.
        for (int i = 0; i < 5; i++) exec_instr(3'd3, 8'(8'h20 + 8'(i)), 1'b0, 0);
        check("ovf_err", error, 1);
        check("ovf_lvl", stack_level, 4);
        do_start();
        exec_instr(3'd4, 8'h00, 1'b0, 0);
        check("unf_err", error, 1);
        do_start();

        // Fetch stall, halt, illegal opcode.
        exec_instr(3'd0, 8'd0, 1'b0, 3);
        exec_instr(3'd5, 8'd0, 1'b0, 0);
        check("halt", halted, 1);
        do_start();
        exec_instr(3'd7, 8'd0, 1'b0, 0);
        check("illegal", error, 1);
        do_start();

        for (int n = 0; n < 200; n++) begin
            if (exp_halt || exp_err) begin
                do_start();
            end else begin
                r = $urandom_range(0, 15);
                if (r < 4)       op = 3'd0;
                else if (r < 6)  op = 3'd1;
                else if (r < 9)  op = 3'd2;
                else if (r < 12) op = 3'd3;
                else if (r < 14) op = 3'd4;
                else if (r < 15) op = 3'd5;
                else             op = 3'($urandom_range(6, 7));
                exec_instr(op, 8'($urandom), 1'($urandom), $urandom_range(0, 2));
            end
        end
        if (exp_halt || exp_err) do_start();

        // Asynchronous reset in the middle of EXEC.
        exec_instr(3'd3, 8'h33, 1'b0, 0);
        instr_valid = 1'b1; opcode = 3'd0; target = '0; cond_z = 1'b0;
        @(negedge clk);
        instr_valid = 1'b0;
        check("pre_rst_cnt", pc_count_en, 1);
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
